csa_nibble_seq_ctrl: RTL and testbench
======================================

Name: csa_nibble_seq_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands using one shared 4-bit carry-select adder slice, one nibble per cycle, LSB nibble first.
- Carry is registered between nibbles.
- Sits between a requester and consumer with valid/ready handshakes on both sides.
- Trades latency for area against a full-width carry-select adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NIB, WIDTH/4, derived nibble count (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  request carries valid operands
in_ready  output  1  controller can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in of the full addition
out_valid  output  1  sum/cout hold a completed result
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result, a+b+cin modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE; nibble index, carry register and operand registers clear.
  - Registered outputs reset to: out_valid=0, sum=0, cout=0.
  - in_ready and busy are decoded from state. While rst is high, in_ready=0 and busy=0.
  - After the first edge with rst low, in_ready=1.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1, busy=0. An edge with in_valid&in_ready latches a, b and cin, sets idx=0 and moves to RUN.
  - RUN: in_ready=0, busy=1. Each edge, the slice computes nibble idx from a[4idx+3:4idx], b[4idx+3:4idx] and the carry register. The result nibble is stored internally, carry_reg takes the slice carry-out, and idx increments. The edge that processes idx=NIB-1 moves to DONE, loads sum from the assembled nibbles, loads cout from the final slice carry, and sets out_valid=1.
  - DONE: in_ready=0, busy=1, out_valid=1. sum and cout stay stable. An edge with out_ready=1 clears out_valid and moves to IDLE. sum and cout keep their value until the next DONE entry.
- Latency and throughput:
  - Accept at edge k gives out_valid high after edge k+NIB.
  - Back-to-back issue period is NIB+2 cycles: the out handshake at edge k+NIB+1, then the next accept at edge k+NIB+2.
  - in_ready never bypasses DONE. The handshake edge and a new accept cannot coincide.
- Slice arithmetic:
  - The slice computes two 4-bit sums, one with carry 0 and one with carry 1, and selects between them by carry_reg.
  - It must be bit-exact with a 4-bit ripple add.
- Boundary conditions:
  - in_valid while busy is ignored; operands are not sampled.
  - Input operands may change after acceptance without affecting the result.
  - out_ready while not in DONE has no effect.
  - The carry chain propagates across all nibbles, e.g. all-ones plus 1.
  - rst high in any state, including mid-RUN or in DONE with out_valid=1, aborts the operation in the same edge. No partial result becomes visible.
  - The final-nibble carry is cout. No overflow flag is produced.
- Scheduling: no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid rises exactly 4 cycles after the accept edge; sum=0x5555, cout=0; busy high for 5 cycles total.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
- Backpressure:
  - out_ready=0 for 5 cycles after out_valid -> out_valid, sum and cout held, in_ready=0.
  - A new in_valid with a=0x00FF, b=0x0F01 during this window is not accepted.
  - After out_ready pulses, that request is accepted -> sum=0x1000, cout=0.
- Mid-operation reset: rst=1 for one edge after 2 RUN cycles of 0xAAAA+0x5555 -> next cycle out_valid=0, sum=0x0000, busy=0; in_ready=1 after rst drops. A following 0x0001+0x0001 with cin=1 gives sum=0x0003.
- Streaming: in_valid and out_ready held 1 with 20 random operand pairs -> one result every 6 cycles; all sums and couts match the reference model.
- WIDTH=8: 0xF0+0x10 with cin=0 -> sum=0x00, cout=1, latency 2 cycles.

Source files
------------

// File: rtl/csa_nibble_seq_ctrl.sv
// Sequential WIDTH-bit adder that reuses one 4-bit carry-select slice, LSB nibble first.
// The carry between nibbles is registered. Requests and results use valid/ready handshakes.
module csa_nibble_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [IdxW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
    logic             cout_q, out_valid_q, in_ready_q, busy_q;

    logic [4:0] sel0, sel1, slice;

    // Both carry candidates are computed up front; the registered carry only picks one.
    always_comb begin
        sel0  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]};
        sel1  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + 5'd1;
        slice = carry_q ? sel1 : sel0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    // Operands shift down so the slice always sees the current nibble at [3:0].
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    acc_q   <= {slice[3:0], acc_q[WIDTH-1:4]};
                    carry_q <= slice[4];
                    idx_q   <= idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        sum_q       <= {slice[3:0], acc_q[WIDTH-1:4]};
                        cout_q      <= slice[4];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_csa_nibble_seq_ctrl.sv
// Self-checking bench for csa_nibble_seq_ctrl: a 16-bit instance for most scenarios and an
// 8-bit instance for the narrow-width case, with results predicted by plain integer addition.
module tb_csa_nibble_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b1;
    logic        cout, busy;
    logic [15:0] a = '0, b = '0, sum;

    logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, out_valid8, out_ready8 = 1'b1;
    logic       cout8, busy8;
    logic [7:0] a8 = '0, b8 = '0, sum8;

    int total = 0;
    int bad   = 0;

    csa_nibble_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .busy(busy)
    );

    csa_nibble_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8),
        .busy(busy8)
    );

    // Full-width reference: {cout, sum} is simply a + b + cin.
    function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
        return {1'b0, x} + {1'b0, y} + 17'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with out_ready held high; report latency, result and busy cycles.
    task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                        output int lat, output logic [15:0] s, output logic c,
                        output int bcnt);
        int g;
        lat  = -1;
        s    = 'x;
        c    = 1'bx;
        bcnt = 0;
        g    = 0;
        while (!in_ready && g < 30) begin
            tick();
            g++;
        end
        if (!in_ready) return;
        a = ia; b = ib; cin = ic; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        g = 0;
        while (g < 40) begin
            if (busy) bcnt++;
            if (out_valid && lat < 0) begin
                lat = g; s = sum; c = cout;
            end
            if (!busy) break;
            tick();
            g++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++;
        if ({out_valid, cout, sum} !== 18'd0) begin
            bad++; $display("FAIL reset_outputs got ov=%b cout=%b sum=%h exp 0", out_valid, cout, sum);
        end
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [15:0] s;
        logic c;
        out_ready = 1'b1;
        op16(16'h1234, 16'h4321, 1'b0, lat, s, c, bc);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        total++;
        if (s !== 16'h5555) begin bad++; $display("FAIL basic_sum got=%h exp=5555", s); end
        total++;
        if (c !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b exp=0", c); end
        total++;
        if (bc !== 5) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc); end
    endtask

    task automatic test_carry_chain();
        logic [15:0] va[3] = '{16'hFFFF, 16'hFFFF, 16'h8000};
        logic [15:0] vb[3] = '{16'h0001, 16'h0000, 16'h8000};
        logic        vc[3] = '{1'b0, 1'b1, 1'b0};
        int lat, bc;
        logic [15:0] s;
        logic c;
        logic [16:0] e;
        for (int i = 0; i < 3; i++) begin
            op16(va[i], vb[i], vc[i], lat, s, c, bc);
            e = ref16(va[i], vb[i], vc[i]);
            total++;
            if ({c, s} !== e || e !== 17'h10000) begin
                bad++;
                $display("FAIL carry_chain_%0d got cout=%b sum=%h exp cout=1 sum=0000", i, c, s);
            end
        end
    endtask

    task automatic test_backpressure();
        int g;
        logic [16:0] e1, e2;
        e1 = ref16(16'h1234, 16'h0001, 1'b1);
        e2 = ref16(16'h00FF, 16'h0F01, 1'b0);
        out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 30) begin tick(); g++; end
        a = 16'h1234; b = 16'h0001; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 20) begin tick(); g++; end
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_result got ov=%b exp=1", out_valid); end
        a = 16'h00FF; b = 16'h0F01; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({out_valid, in_ready, cout, sum} !== {2'b10, e1}) begin
                bad++;
                $display("FAIL bp_hold_%0d got ov=%b rdy=%b cout=%b sum=%h exp ov=1 rdy=0 cout=%b sum=%h",
                         i, out_valid, in_ready, cout, sum, e1[16], e1[15:0]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        total++;
        if ({busy, in_ready} !== 2'b10) begin
            bad++; $display("FAIL bp_accept got busy=%b rdy=%b exp busy=1 rdy=0", busy, in_ready);
        end
        out_ready = 1'b1;
        g = 0;
        while (!out_valid && g < 20) begin tick(); g++; end
        total++;
        if ({out_valid, cout, sum} !== {1'b1, e2} || e2 !== 17'h01000) begin
            bad++; $display("FAIL bp_second_result got ov=%b cout=%b sum=%h exp ov=1 cout=0 sum=1000",
                            out_valid, cout, sum);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int g, lat, bc;
        logic [15:0] s;
        logic c;
        out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 30) begin tick(); g++; end
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({out_valid, cout, sum, busy, in_ready} !== 20'd0) begin
            bad++; $display("FAIL midrun_reset got ov=%b cout=%b sum=%h busy=%b rdy=%b exp all 0",
                            out_valid, cout, sum, busy, in_ready);
        end
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrun_reset_ready got=%b exp=1", in_ready); end
        op16(16'h0001, 16'h0001, 1'b1, lat, s, c, bc);
        total++;
        if ({c, s} !== ref16(16'h0001, 16'h0001, 1'b1)) begin
            bad++; $display("FAIL after_reset_sum got cout=%b sum=%h exp cout=0 sum=0003", c, s);
        end
        // Abort while a result is being presented.
        out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 30) begin tick(); g++; end
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 20) begin tick(); g++; end
        rst = 1'b1;
        tick();
        total++;
        if ({out_valid, cout, sum, busy} !== 19'd0) begin
            bad++; $display("FAIL done_reset got ov=%b cout=%b sum=%h busy=%b exp all 0",
                            out_valid, cout, sum, busy);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] opa[20], opb[20];
        logic        opc[20];
        logic [16:0] expq[$];
        logic [16:0] e;
        int next, got, cyc, last_acc;
        bit acc, hs;
        for (int i = 0; i < 20; i++) begin
            opa[i] = 16'($urandom); opb[i] = 16'($urandom); opc[i] = 1'($urandom);
        end
        next = 0; got = 0; cyc = 0; last_acc = -1;
        out_ready = 1'b1;
        a = opa[0]; b = opb[0]; cin = opc[0]; in_valid = 1'b1;
        while (got < 20 && cyc < 400) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL stream_spurious got cout=%b sum=%h exp none", cout, sum);
                end else begin
                    e = expq.pop_front();
                    if ({cout, sum} !== e) begin
                        bad++; $display("FAIL stream_result_%0d got cout=%b sum=%h exp cout=%b sum=%h",
                                        got, cout, sum, e[16], e[15:0]);
                    end
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                expq.push_back(ref16(opa[next], opb[next], opc[next]));
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc !== 6) begin
                        bad++; $display("FAIL stream_period got=%0d exp=6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                next++;
                if (next < 20) begin
                    a = opa[next]; b = opb[next]; cin = opc[next];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (got !== 20) begin bad++; $display("FAIL stream_count got=%0d exp=20", got); end
        tick();
    endtask

    task automatic test_width8();
        int g;
        logic [8:0] e;
        e = {1'b0, 8'hF0} + {1'b0, 8'h10};
        out_ready8 = 1'b1;
        g = 0;
        while (!in_ready8 && g < 30) begin tick(); g++; end
        a8 = 8'hF0; b8 = 8'h10; cin8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        a8 = 8'h5A; b8 = 8'hA5;
        g = 0;
        while (!out_valid8 && g < 20) begin tick(); g++; end
        total++;
        if (g !== 2) begin bad++; $display("FAIL w8_latency got=%0d exp=2", g); end
        total++;
        if ({cout8, sum8} !== e || e !== 9'h100) begin
            bad++; $display("FAIL w8_result got cout=%b sum=%h exp cout=1 sum=00", cout8, sum8);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
